// File: rtl/spi_pkg.sv
// Shared constants for the SPI burst transfer controller: byte width and the
// FSM state encoding.
package spi_pkg;

    localparam int BYTE_W = 8;

    typedef logic [BYTE_W-1:0] byte_t;

    localparam logic [2:0] ST_IDLE    = 3'd0;
    localparam logic [2:0] ST_SETUP   = 3'd1;
    localparam logic [2:0] ST_ISSUE   = 3'd2;
    localparam logic [2:0] ST_WAIT    = 3'd3;
    localparam logic [2:0] ST_STORE   = 3'd4;
    localparam logic [2:0] ST_RELEASE = 3'd5;

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with a combinational head and extra-MSB wrap pointers.
// A pop frees space for a concurrent push; a pop of an empty FIFO is dropped.
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 8
) (
    input  logic             i_clk,
    input  logic             i_reset,
    input  logic             i_push,
    input  logic             i_pop,
    input  logic [WIDTH-1:0] i_din,
    output logic [WIDTH-1:0] o_dout,
    output logic             o_full,
    output logic             o_empty
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] PTR_ONE = {{AW{1'b0}}, 1'b1};

    logic [AW:0]      r_wr_ptr;
    logic [AW:0]      r_rd_ptr;
    logic [WIDTH-1:0] r_mem [DEPTH];
    logic             w_do_push;
    logic             w_do_pop;

    assign o_empty   = (r_wr_ptr == r_rd_ptr);
    assign o_full    = (r_wr_ptr[AW] != r_rd_ptr[AW]) &&
                       (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
    assign w_do_pop  = i_pop && !o_empty;
    assign w_do_push = i_push && (!o_full || w_do_pop);
    assign o_dout    = r_mem[r_rd_ptr[AW-1:0]];

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            if (w_do_push) begin
                r_wr_ptr <= r_wr_ptr + PTR_ONE;
            end
            if (w_do_pop) begin
                r_rd_ptr <= r_rd_ptr + PTR_ONE;
            end
        end
    end

    // Storage needs no reset: the head is only consumed when non-empty.
    always_ff @(posedge i_clk) begin
        if (w_do_push) begin
            r_mem[r_wr_ptr[AW-1:0]] <= i_din;
        end
    end

endmodule

// File: rtl/spi_xfer_ctrl.sv
// Burst controller in front of an SPI master: drains a TX FIFO one byte per
// transaction under a single slave-select window and collects replies in an RX FIFO.
//
// state   | meaning
// IDLE    | ss high, waiting for go with TX data queued
// SETUP   | ss low, one-cycle select setup guard
// ISSUE   | waiting for master ready, then pop TX head and start
// WAIT    | transaction in flight, tx byte held stable
// STORE   | push received byte, decide next byte or release
// RELEASE | last cycle with ss low
module spi_xfer_ctrl
    import spi_pkg::*;
#(
    parameter int DEPTH = 8
) (
    input  logic              i_clk,
    input  logic              i_reset,
    input  logic              i_cfg_cpol,
    input  logic              i_cfg_cpha,
    input  logic              i_wr_en,
    input  logic [BYTE_W-1:0] i_wr_data,
    output logic              o_tx_full,
    input  logic              i_go,
    input  logic              i_rd_en,
    output logic [BYTE_W-1:0] o_rd_data,
    output logic              o_rx_empty,
    output logic              o_rx_overflow,
    output logic              o_busy,
    output logic              o_ss,
    output logic              o_spi_cpol,
    output logic              o_spi_cpha,
    output logic              o_spi_start,
    output logic [BYTE_W-1:0] o_spi_tx_data,
    input  logic [BYTE_W-1:0] i_spi_rx_data,
    input  logic              i_spi_done,
    input  logic              i_spi_ready
);

    logic [2:0] r_state;
    logic [2:0] w_state_nxt;

    byte_t r_spi_tx_data;
    byte_t r_rx_byte;
    byte_t r_rd_data;
    logic  r_ss;
    logic  r_start;
    logic  r_cpol;
    logic  r_cpha;
    logic  r_overflow;

    logic  w_tx_full;
    logic  w_tx_empty;
    byte_t w_tx_dout;
    logic  w_rx_full;
    logic  w_rx_empty;
    byte_t w_rx_dout;

    logic  w_issue;
    logic  w_rx_push;
    logic  w_rx_drop;
    logic  w_rd_accept;
    logic  w_tx_more;

    assign w_issue     = (r_state == ST_ISSUE) && i_spi_ready;
    assign w_rx_push   = (r_state == ST_STORE);
    assign w_rx_drop   = w_rx_push && w_rx_full && !i_rd_en;
    assign w_rd_accept = i_rd_en && !w_rx_empty;
    // A host write landing on the STORE decision edge still extends the burst.
    assign w_tx_more   = !w_tx_empty || i_wr_en;

    sync_fifo #(
        .WIDTH (BYTE_W),
        .DEPTH (DEPTH)
    ) u_tx_fifo (
        .i_clk   (i_clk),
        .i_reset (i_reset),
        .i_push  (i_wr_en),
        .i_pop   (w_issue),
        .i_din   (i_wr_data),
        .o_dout  (w_tx_dout),
        .o_full  (w_tx_full),
        .o_empty (w_tx_empty)
    );

    sync_fifo #(
        .WIDTH (BYTE_W),
        .DEPTH (DEPTH)
    ) u_rx_fifo (
        .i_clk   (i_clk),
        .i_reset (i_reset),
        .i_push  (w_rx_push),
        .i_pop   (i_rd_en),
        .i_din   (r_rx_byte),
        .o_dout  (w_rx_dout),
        .o_full  (w_rx_full),
        .o_empty (w_rx_empty)
    );

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE:    if (i_go && !w_tx_empty) w_state_nxt = ST_SETUP;
            ST_SETUP:   w_state_nxt = ST_ISSUE;
            ST_ISSUE:   if (i_spi_ready) w_state_nxt = ST_WAIT;
            ST_WAIT:    if (i_spi_done) w_state_nxt = ST_STORE;
            ST_STORE:   w_state_nxt = w_tx_more ? ST_ISSUE : ST_RELEASE;
            ST_RELEASE: w_state_nxt = ST_IDLE;
            default:    w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_state       <= ST_IDLE;
            r_ss          <= 1'b1;
            r_start       <= 1'b0;
            r_spi_tx_data <= '0;
            r_cpol        <= 1'b0;
            r_cpha        <= 1'b0;
            r_rx_byte     <= '0;
            r_rd_data     <= '0;
            r_overflow    <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_start <= w_issue;
            if ((r_state == ST_IDLE) && (w_state_nxt == ST_SETUP)) begin
                r_cpol <= i_cfg_cpol;
                r_cpha <= i_cfg_cpha;
                r_ss   <= 1'b0;
            end
            if (r_state == ST_RELEASE) begin
                r_ss <= 1'b1;
            end
            if (w_issue) begin
                r_spi_tx_data <= w_tx_dout;
            end
            if ((r_state == ST_WAIT) && i_spi_done) begin
                r_rx_byte <= i_spi_rx_data;
            end
            if (w_rd_accept) begin
                r_rd_data <= w_rx_dout;
            end
            if (w_rx_drop) begin
                r_overflow <= 1'b1;
            end
        end
    end

    assign o_tx_full     = w_tx_full;
    assign o_rd_data     = r_rd_data;
    assign o_rx_empty    = w_rx_empty;
    assign o_rx_overflow = r_overflow;
    assign o_busy        = (r_state != ST_IDLE);
    assign o_ss          = r_ss;
    assign o_spi_cpol    = r_cpol;
    assign o_spi_cpha    = r_cpha;
    assign o_spi_start   = r_start;
    assign o_spi_tx_data = r_spi_tx_data;

endmodule

// File: tb/tb_spi_xfer_ctrl.sv
// Directed bench for spi_xfer_ctrl with a loopback SPI master model that echoes
// each transmitted byte back after a fixed latency.
module tb_spi_xfer_ctrl;

    localparam int MLAT = 4;

    logic       clk = 1'b0;
    logic       reset;
    logic       cfg_cpol, cfg_cpha;
    logic       wr_en;
    logic [7:0] wr_data;
    logic       tx_full;
    logic       go;
    logic       rd_en;
    logic [7:0] rd_data;
    logic       rx_empty, rx_overflow, busy, ss;
    logic       spi_cpol, spi_cpha, spi_start;
    logic [7:0] spi_tx_data;
    logic [7:0] spi_rx_data;
    logic       spi_done, spi_ready;

    int checks = 0;
    int errors = 0;

    int         cyc;
    int         m_cnt;
    logic [7:0] m_byte;
    int         m_starts, m_dones;
    logic [7:0] m_tx_log [0:31];
    int         first_start_cyc, first_done_cyc, last_done_cyc;
    int         ss_fall_cyc, ss_rise_cyc, ss_rises, rx_fall_cyc;
    logic       prev_ss, prev_rx_empty;

    always #5 clk = ~clk;

    spi_xfer_ctrl #(.DEPTH(8)) dut (
        .i_clk         (clk),
        .i_reset       (reset),
        .i_cfg_cpol    (cfg_cpol),
        .i_cfg_cpha    (cfg_cpha),
        .i_wr_en       (wr_en),
        .i_wr_data     (wr_data),
        .o_tx_full     (tx_full),
        .i_go          (go),
        .i_rd_en       (rd_en),
        .o_rd_data     (rd_data),
        .o_rx_empty    (rx_empty),
        .o_rx_overflow (rx_overflow),
        .o_busy        (busy),
        .o_ss          (ss),
        .o_spi_cpol    (spi_cpol),
        .o_spi_cpha    (spi_cpha),
        .o_spi_start   (spi_start),
        .o_spi_tx_data (spi_tx_data),
        .i_spi_rx_data (spi_rx_data),
        .i_spi_done    (spi_done),
        .i_spi_ready   (spi_ready)
    );

    // Master model and event monitor share one process so cycle stamps agree.
    initial begin
        spi_ready = 1'b1; spi_done = 1'b0; spi_rx_data = 8'h00;
        cyc = 0; m_cnt = 0; m_byte = 8'h00;
        prev_ss = 1'b1; prev_rx_empty = 1'b1;
        forever begin
            @(posedge clk); #1;
            cyc++;
            spi_done = 1'b0;
            if (reset) begin
                m_cnt = 0;
                spi_ready = 1'b1;
            end else if (spi_start) begin
                if (m_starts < 32) m_tx_log[m_starts] = spi_tx_data;
                m_starts++;
                if (first_start_cyc < 0) first_start_cyc = cyc;
                m_byte = spi_tx_data;
                m_cnt = MLAT;
                spi_ready = 1'b0;
            end else if (m_cnt > 0) begin
                m_cnt--;
                if (m_cnt == 0) begin
                    spi_done = 1'b1;
                    spi_rx_data = m_byte;
                    spi_ready = 1'b1;
                    m_dones++;
                    if (first_done_cyc < 0) first_done_cyc = cyc;
                    last_done_cyc = cyc;
                end
            end
            if (prev_ss && !ss) ss_fall_cyc = cyc;
            if (!prev_ss && ss) begin ss_rises++; ss_rise_cyc = cyc; end
            if (prev_rx_empty && !rx_empty && rx_fall_cyc < 0) rx_fall_cyc = cyc;
            prev_ss = ss;
            prev_rx_empty = rx_empty;
        end
    end

    task automatic clear_mon();
        m_starts = 0; m_dones = 0; ss_rises = 0;
        first_start_cyc = -1; first_done_cyc = -1; last_done_cyc = -1;
        ss_fall_cyc = -1; ss_rise_cyc = -1; rx_fall_cyc = -1;
    endtask

    task automatic push_byte(input logic [7:0] b);
        wr_en = 1'b1; wr_data = b;
        @(negedge clk);
        wr_en = 1'b0;
    endtask

    task automatic pulse_go();
        go = 1'b1;
        @(negedge clk);
        go = 1'b0;
    endtask

    task automatic read_byte(output logic [7:0] b);
        rd_en = 1'b1;
        @(negedge clk);
        rd_en = 1'b0;
        b = rd_data;
    endtask

    task automatic wait_idle(input string name);
        int n = 0;
        while (busy && n < 500) begin @(negedge clk); n++; end
        checks++;
        if (busy !== 1'b0) begin errors++; $display("FAIL %s idle timeout busy=%b want 0", name, busy); end
    endtask

    task automatic wait_starts(input int target, input string name);
        int n = 0;
        while (m_starts < target && n < 200) begin @(negedge clk); n++; end
        checks++;
        if (m_starts < target) begin errors++; $display("FAIL %s start timeout got %0d want %0d", name, m_starts, target); end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (3) @(negedge clk);
        checks++; if (ss !== 1'b1) begin errors++; $display("FAIL rst_ss got %b want 1", ss); end
        checks++; if (rx_empty !== 1'b1) begin errors++; $display("FAIL rst_rx_empty got %b want 1", rx_empty); end
        checks++; if (tx_full !== 1'b0) begin errors++; $display("FAIL rst_tx_full got %b want 0", tx_full); end
        checks++; if (rd_data !== 8'h00) begin errors++; $display("FAIL rst_rd_data got %h want 00", rd_data); end
        checks++; if (rx_overflow !== 1'b0) begin errors++; $display("FAIL rst_ovf got %b want 0", rx_overflow); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rst_busy got %b want 0", busy); end
        checks++; if (spi_start !== 1'b0) begin errors++; $display("FAIL rst_start got %b want 0", spi_start); end
        checks++; if (spi_tx_data !== 8'h00) begin errors++; $display("FAIL rst_tx_data got %h want 00", spi_tx_data); end
        checks++; if ({spi_cpol, spi_cpha} !== 2'b00) begin errors++; $display("FAIL rst_mode got %b want 00", {spi_cpol, spi_cpha}); end
        reset = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_basic();
        logic [7:0] b;
        clear_mon();
        push_byte(8'hA5);
        push_byte(8'h3C);
        cfg_cpol = 1'b0; cfg_cpha = 1'b0;
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL basic_pre_busy got %b want 0", busy); end
        pulse_go();
        checks++; if (ss !== 1'b0) begin errors++; $display("FAIL basic_go_ss got %b want 0", ss); end
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL basic_go_busy got %b want 1", busy); end
        wait_idle("basic");
        checks++; if (m_starts !== 2) begin errors++; $display("FAIL basic_starts got %0d want 2", m_starts); end
        checks++; if (m_tx_log[0] !== 8'hA5) begin errors++; $display("FAIL basic_tx0 got %h want a5", m_tx_log[0]); end
        checks++; if (m_tx_log[1] !== 8'h3C) begin errors++; $display("FAIL basic_tx1 got %h want 3c", m_tx_log[1]); end
        checks++; if (ss_rises !== 1) begin errors++; $display("FAIL basic_ss_rises got %0d want 1", ss_rises); end
        checks++; if (first_start_cyc - ss_fall_cyc < 2) begin errors++; $display("FAIL basic_ss_to_start got %0d want >=2", first_start_cyc - ss_fall_cyc); end
        checks++; if (rx_fall_cyc - first_done_cyc !== 2) begin errors++; $display("FAIL basic_done_to_rx got %0d want 2", rx_fall_cyc - first_done_cyc); end
        read_byte(b);
        checks++; if (b !== 8'hA5) begin errors++; $display("FAIL basic_rx0 got %h want a5", b); end
        read_byte(b);
        checks++; if (b !== 8'h3C) begin errors++; $display("FAIL basic_rx1 got %h want 3c", b); end
        checks++; if (rx_empty !== 1'b1) begin errors++; $display("FAIL basic_rx_empty got %b want 1", rx_empty); end
    endtask

    task automatic test_full();
        logic [7:0] b, exp;
        clear_mon();
        for (int i = 0; i < 8; i++) push_byte(8'h10 + 8'(i));
        checks++; if (tx_full !== 1'b1) begin errors++; $display("FAIL full_flag got %b want 1", tx_full); end
        push_byte(8'h99);
        checks++; if (tx_full !== 1'b1) begin errors++; $display("FAIL full_flag9 got %b want 1", tx_full); end
        cfg_cpol = 1'b1; cfg_cpha = 1'b1;
        pulse_go();
        cfg_cpol = 1'b0; cfg_cpha = 1'b0;
        wait_idle("full");
        checks++; if (m_starts !== 8) begin errors++; $display("FAIL full_starts got %0d want 8", m_starts); end
        for (int i = 0; i < 8; i++) begin
            exp = 8'h10 + 8'(i);
            checks++; if (m_tx_log[i] !== exp) begin errors++; $display("FAIL full_tx%0d got %h want %h", i, m_tx_log[i], exp); end
        end
        checks++; if (ss_rise_cyc - last_done_cyc !== 3) begin errors++; $display("FAIL full_store_to_ss got %0d want 3 (done->ss)", ss_rise_cyc - last_done_cyc); end
        checks++; if ({spi_cpol, spi_cpha} !== 2'b11) begin errors++; $display("FAIL full_mode got %b want 11", {spi_cpol, spi_cpha}); end
        for (int i = 0; i < 8; i++) begin
            read_byte(b);
            exp = 8'h10 + 8'(i);
            checks++; if (b !== exp) begin errors++; $display("FAIL full_rx%0d got %h want %h", i, b, exp); end
        end
    endtask

    task automatic test_overflow();
        logic [7:0] b, exp;
        for (int i = 0; i < 8; i++) push_byte(8'h20 + 8'(i));
        pulse_go();
        wait_idle("ovf1");
        checks++; if (rx_overflow !== 1'b0) begin errors++; $display("FAIL ovf_early got %b want 0", rx_overflow); end
        clear_mon();
        for (int i = 0; i < 8; i++) push_byte(8'h30 + 8'(i));
        pulse_go();
        wait_idle("ovf2");
        checks++; if (m_starts !== 8) begin errors++; $display("FAIL ovf_starts got %0d want 8", m_starts); end
        checks++; if (rx_overflow !== 1'b1) begin errors++; $display("FAIL ovf_flag got %b want 1", rx_overflow); end
        for (int i = 0; i < 8; i++) begin
            read_byte(b);
            exp = 8'h20 + 8'(i);
            checks++; if (b !== exp) begin errors++; $display("FAIL ovf_rx%0d got %h want %h", i, b, exp); end
        end
        checks++; if (rx_empty !== 1'b1) begin errors++; $display("FAIL ovf_rx_empty got %b want 1", rx_empty); end
        checks++; if (rx_overflow !== 1'b1) begin errors++; $display("FAIL ovf_sticky got %b want 1", rx_overflow); end
    endtask

    task automatic test_extend();
        logic [7:0] b;
        int n;
        clear_mon();
        push_byte(8'h77);
        pulse_go();
        wait_starts(1, "ext_wait");
        push_byte(8'h11);
        wait_idle("ext");
        checks++; if (m_starts !== 2) begin errors++; $display("FAIL ext_starts got %0d want 2", m_starts); end
        checks++; if (m_tx_log[1] !== 8'h11) begin errors++; $display("FAIL ext_tx1 got %h want 11", m_tx_log[1]); end
        checks++; if (ss_rises !== 1) begin errors++; $display("FAIL ext_ss_rises got %0d want 1", ss_rises); end
        read_byte(b);
        checks++; if (b !== 8'h77) begin errors++; $display("FAIL ext_rx0 got %h want 77", b); end
        read_byte(b);
        checks++; if (b !== 8'h11) begin errors++; $display("FAIL ext_rx1 got %h want 11", b); end
        // Write presented exactly during the STORE cycle.
        clear_mon();
        push_byte(8'h55);
        pulse_go();
        n = 0;
        while (!spi_done && n < 200) begin @(negedge clk); n++; end
        checks++; if (spi_done !== 1'b1) begin errors++; $display("FAIL edge_done timeout got %b want 1", spi_done); end
        @(negedge clk);
        push_byte(8'h22);
        wait_idle("edge");
        checks++; if (m_starts !== 2) begin errors++; $display("FAIL edge_starts got %0d want 2", m_starts); end
        checks++; if (ss_rises !== 1) begin errors++; $display("FAIL edge_ss_rises got %0d want 1", ss_rises); end
        read_byte(b);
        read_byte(b);
        checks++; if (b !== 8'h22) begin errors++; $display("FAIL edge_rx1 got %h want 22", b); end
    endtask

    task automatic test_reset_mid();
        push_byte(8'h44);
        pulse_go();
        wait_idle("rmid_pre");
        clear_mon();
        push_byte(8'h45);
        push_byte(8'h46);
        pulse_go();
        wait_starts(1, "rmid_wait");
        reset = 1'b1;
        @(negedge clk);
        checks++; if (ss !== 1'b1) begin errors++; $display("FAIL rmid_ss got %b want 1", ss); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rmid_busy got %b want 0", busy); end
        checks++; if (rx_empty !== 1'b1) begin errors++; $display("FAIL rmid_rx_empty got %b want 1", rx_empty); end
        checks++; if (spi_start !== 1'b0) begin errors++; $display("FAIL rmid_start got %b want 0", spi_start); end
        checks++; if (rx_overflow !== 1'b0) begin errors++; $display("FAIL rmid_ovf got %b want 0", rx_overflow); end
        reset = 1'b0;
        repeat (12) @(negedge clk);
        checks++; if (m_starts !== 1) begin errors++; $display("FAIL rmid_starts got %0d want 1", m_starts); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rmid_busy_after got %b want 0", busy); end
    endtask

    task automatic test_go_ignored();
        logic [7:0] b;
        clear_mon();
        pulse_go();
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL goe_busy got %b want 0", busy); end
        checks++; if (ss !== 1'b1) begin errors++; $display("FAIL goe_ss got %b want 1", ss); end
        repeat (10) @(negedge clk);
        checks++; if (m_starts !== 0) begin errors++; $display("FAIL goe_starts got %0d want 0", m_starts); end
        push_byte(8'h66);
        pulse_go();
        for (int i = 0; i < 4; i++) pulse_go();
        wait_idle("gob");
        repeat (10) @(negedge clk);
        checks++; if (m_starts !== 1) begin errors++; $display("FAIL gob_starts got %0d want 1", m_starts); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL gob_busy got %b want 0", busy); end
        read_byte(b);
        checks++; if (b !== 8'h66) begin errors++; $display("FAIL gob_rx got %h want 66", b); end
    endtask

    initial begin
        reset = 1'b1; cfg_cpol = 1'b0; cfg_cpha = 1'b0;
        wr_en = 1'b0; wr_data = 8'h00; go = 1'b0; rd_en = 1'b0;
        clear_mon();
        @(negedge clk);
        test_reset();
        test_basic();
        test_full();
        test_overflow();
        test_extend();
        test_reset_mid();
        test_go_ignored();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
